ahb3lite_sram_slave: RTL and testbench
======================================

AHB3LITE_SRAM_SLAVE -- requirements
Module: ahb3lite_sram_slave

Interface
REQ-001 Parameter HADDR_SIZE, default 32, address bus width.
REQ-002 Parameter HDATA_SIZE, default 32, data bus width; only 32 supported.
REQ-003 Parameter MEM_DEPTH, default 256, number of 32-bit words in the storage array.
REQ-004 Parameter WAIT_STATES, default 1, range 0..3, wait cycles inserted per OKAY data phase.
REQ-005 HCLK  input  1  single clock; all state on rising edge.
REQ-006 HRESET  input  1  reset, asynchronous, active-high.
REQ-007 HSELx  input  1  slave select.
REQ-008 HADDR  input  HADDR_SIZE  byte address, address phase.
REQ-009 HWRITE  input  1  1 = write, 0 = read.
REQ-010 HSIZE  input  3  transfer size, 0 byte / 1 halfword / 2 word.
REQ-011 HBURST  input  3  burst type; accepted, not used for decode.
REQ-012 HPROT  input  4  protection; accepted, ignored.
REQ-013 HTRANS  input  2  IDLE 0, BUSY 1, NONSEQ 2, SEQ 3.
REQ-014 HREADY  input  1  bus-level ready; previous transfer complete.
REQ-015 HWDATA  input  HDATA_SIZE  write data, data phase.
REQ-016 HRDATA  output  HDATA_SIZE  read data, data phase.
REQ-017 HREADYOUT  output  1  slave ready; 0 extends the data phase.
REQ-018 HRESP  output  1  0 OKAY, 1 ERROR.

Function
REQ-019 The slave SHALL accept an address phase only when HSELx=1, HREADY=1 and HTRANS is NONSEQ or SEQ; it SHALL then register HADDR, HWRITE and HSIZE.
REQ-020 If HSELx=1 and HREADY=1 with HTRANS IDLE or BUSY, the next cycle SHALL be a zero-wait OKAY with HREADYOUT=1 and HRESP=0.
REQ-021 FSM states SHALL be IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-022 FSM transitions on an accepted legal transfer:
- WAIT_STATES=0: go to DATA.
- Otherwise: go to WAIT, with a down-counter loaded to WAIT_STATES.
REQ-023 In WAIT, HREADYOUT SHALL be 0 and HRESP 0; the slave SHALL move to DATA when the counter reaches 1.
REQ-024 In DATA, HREADYOUT SHALL be 1 and HRESP 0; the transfer completes this cycle.
REQ-025 A transfer SHALL be illegal if any of the following holds:
- HADDR >= MEM_DEPTH*4;
- HSIZE > 2;
- HSIZE=1 and HADDR[0]=1;
- HSIZE=2 and HADDR[1:0]!=0.
REQ-026 An illegal transfer SHALL produce two cycles: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory SHALL be left unmodified.
REQ-027 A write SHALL update only the byte lanes selected by HSIZE and HADDR[1:0] (little-endian), using HWDATA sampled in the DATA cycle.
REQ-028 A read SHALL drive the full addressed word on HRDATA in the DATA cycle; HRDATA SHALL be 0 in all other cycles.
REQ-029 In a DATA or ERR2 cycle, a new address phase presented with HREADY=1 SHALL be accepted (pipelined back-to-back); otherwise the FSM returns to IDLE.
REQ-030 Address phases SHALL be ignored when HREADY=0 or HSELx=0.
REQ-031 A read to an address written by the immediately preceding transfer SHALL return the newly written data.
REQ-032 If the master issues IDLE in ERR1, the slave SHALL still complete ERR2.

Reset
REQ-033 While HRESET=1, outputs SHALL be HREADYOUT=1, HRESP=0 and HRDATA=0, with FSM in IDLE and counter 0; this applies asynchronously, including mid-transfer.
REQ-034 Memory contents SHALL NOT be reset; an aborted write SHALL leave the target word unmodified.

Structure
REQ-035 Package ahb_pkg SHALL hold:
- htrans_t (IDLE/BUSY/NONSEQ/SEQ);
- hsize_t;
- hburst_t;
- the slave FSM state enum;
- constants HRESP_OKAY=0 and HRESP_ERROR=1.
REQ-036 The storage array with byte-lane write enables SHALL be a sub-module, ahb_sram_mem.

Verification
REQ-037 WAIT_STATES=1; word write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase has exactly one HREADYOUT=0 cycle; read returns 0xDEADBEEF with HRESP=0.
REQ-038 Byte write 0xAB to 0x21 over word 0x00000000 -> read of 0x20 returns 0x0000AB00.
REQ-039 Word read at 0x402 with MEM_DEPTH=256 -> HREADYOUT/HRESP = 0/1 then 1/1; memory unchanged.
REQ-040 WAIT_STATES=0; back-to-back NONSEQ writes to 0x0, 0x4, 0x8, then reads -> HREADYOUT stays 1 throughout; data returned in order.
REQ-041 HRESET asserted during WAIT of a write to 0x30 -> same cycle HREADYOUT=1, HRESP=0; word at 0x30 retains its old value.
REQ-042 HSELx=1 with HTRANS=IDLE, then HTRANS=BUSY -> each gives a one-cycle OKAY; no memory access.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB3-Lite bus types, slave FSM states, response codes and byte-lane decode
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;
    typedef enum logic [2:0] {
        HSIZE_BYTE, HSIZE_HWORD, HSIZE_WORD, HSIZE_DWORD,
        HSIZE_4WORD, HSIZE_8WORD, HSIZE_16WORD, HSIZE_32WORD
    } hsize_t;
    typedef enum logic [2:0] {
        HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
        HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16
    } hburst_t;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} slv_state_t;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    // little-endian lane enables for an already-legal (naturally aligned, <= word) access
    function automatic logic [3:0] byte_en(input hsize_t size, input logic [1:0] a);
        return size == HSIZE_BYTE ? 4'b0001 << a : size == HSIZE_HWORD ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: word-organised storage with per-byte write enables and asynchronous read
// ports: clk_i clock; we_i/be_i write strobe and lane enables; addr_i word index;
//        wdata_i write word; rdata_o addressed word (combinational). Contents are never reset.
module ahb_sram_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
)(
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave: AHB3-Lite SRAM slave with configurable wait states and ERROR responses
// ports: HCLK/HRESET clock and async active-high reset; HSELx, HADDR, HWRITE, HSIZE, HBURST,
//        HPROT, HTRANS, HREADY address-phase inputs; HWDATA write data; HRDATA, HREADYOUT,
//        HRESP data-phase outputs. HBURST and HPROT are accepted but play no part in decode.
module ahb3lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
)(
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELx,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam logic [HADDR_SIZE:0] LIMIT = (HADDR_SIZE + 1)'(MEM_DEPTH * 4);
    slv_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic        write_q, write_d;
    hsize_t      size_q, size_d;
    logic        ready_phase, accept, illegal, we;
    logic [31:0] rdata;
    logic        unused;
    assign unused = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:AW+2]};
    // a new address phase can only be taken while this slave is not stretching a data phase
    assign ready_phase = state_q inside {ST_IDLE, ST_DATA, ST_ERR2};
    assign accept = ready_phase & HSELx & HREADY & (HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ});
    assign illegal = ({1'b0, HADDR} >= LIMIT) | (HSIZE > 3'd2)
                   | (HSIZE == 3'd1 & HADDR[0]) | (HSIZE == 3'd2 & |HADDR[1:0]);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        if (accept) begin
            addr_d  = HADDR[AW+1:0];
            write_d = HWRITE;
            size_d  = hsize_t'(HSIZE);
            state_d = illegal ? ST_ERR1 : WAIT_STATES == 0 ? ST_DATA : ST_WAIT;
            cnt_d   = illegal ? 2'd0 : 2'(WAIT_STATES);
        end else if (state_q == ST_WAIT) begin
            state_d = cnt_q == 2'd1 ? ST_DATA : ST_WAIT;
            cnt_d   = cnt_q - 2'd1;
        end else begin
            state_d = state_q == ST_ERR1 ? ST_ERR2 : ST_IDLE;
            cnt_d   = 2'd0;
        end
    end
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= HSIZE_BYTE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end
    // illegal transfers never reach DATA, so memory is only touched by legal writes
    assign we = state_q == ST_DATA && write_q;
    ahb_sram_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
        .clk_i   (HCLK),
        .we_i    (we),
        .be_i    (byte_en(size_q, addr_q[1:0])),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (HWDATA),
        .rdata_o (rdata)
    );
    assign HREADYOUT = !(state_q inside {ST_WAIT, ST_ERR1});
    assign HRESP     = state_q inside {ST_ERR1, ST_ERR2} ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = state_q == ST_DATA && !write_q ? rdata : '0;
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb_ahb3lite_sram_slave: randomized bench with a transaction-level reference model per slave
module tb_ahb3lite_sram_slave;
    localparam int DEPTH = 256;
    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
        logic        commit;
        logic [7:0]  widx;
        logic [31:0] mask;
    } exp_t;
    logic clk = 0, rst = 1, hsel = 0, cur = 0, hwrite = 0, hold = 0;
    logic [1:0] htrans = 0;
    logic [2:0] hsize = 0, hburst = 0;
    logic [3:0] hprot = 0;
    logic [31:0] haddr = 0, hwdata = 0, pwdata = 0;
    logic hready, hsel0, hsel1, hro0, hro1, hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;
    int n_tests = 0, n_fail = 0, nwait = 0, tot = 0;
    logic first_resp = 0, cap_resp = 0, exp_bus_rdy = 1;
    logic [31:0] cap_rdata = 0;
    always #5 clk = ~clk;
    assign hsel0 = hsel & ~cur;
    assign hsel1 = hsel & cur;
    assign hready = hro0 & hro1 & ~hold;
    ahb3lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .HCLK(clk), .HRESET(rst), .HSELx(hsel0), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0));
    ahb3lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(rst), .HSELx(hsel1), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(hrdata1), .HREADYOUT(hro1), .HRESP(hresp1));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic exp_t mk(input logic rdy, input logic resp, input logic [31:0] rdata,
                                input logic commit, input logic [7:0] widx, input logic [31:0] mask);
        return '{rdy, resp, rdata, commit, widx, mask};
    endfunction
    // per-slave model: each accepted transfer becomes a list of expected data-phase cycles
    for (genvar g = 0; g < 2; g++) begin : m
        localparam int WS = g == 0 ? 1 : 0;
        exp_t q[$];
        logic [31:0] mem [DEPTH];
        logic exp_rdy, exp_resp;
        logic [31:0] exp_rdata;
        initial begin : model
            exp_t e;
            logic [31:0] a, mask;
            int sz;
            exp_rdy = 1; exp_resp = 0; exp_rdata = 0;
            forever begin
                @(posedge clk or posedge rst);
                if (rst) q.delete();
                else begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        if (e.commit) mem[e.widx] = (mem[e.widx] & ~e.mask) | (hwdata & e.mask);
                    end
                    if (exp_bus_rdy && hsel && cur == 1'(g) && htrans[1]) begin
                        a = haddr;
                        sz = int'(hsize);
                        if (a >= 32'(DEPTH * 4) || sz > 2 || (a & 32'((1 << sz) - 1)) != 0) begin
                            q.push_back(mk(0, 1, 0, 0, 0, 0));
                            q.push_back(mk(1, 1, 0, 0, 0, 0));
                        end else begin
                            for (int i = 0; i < WS; i++) q.push_back(mk(0, 0, 0, 0, 0, 0));
                            mask = 0;
                            for (int b = 0; b < (1 << sz); b++) mask[8 * (int'(a[1:0]) + b) +: 8] = 8'hff;
                            q.push_back(mk(1, 0, hwrite ? 32'h0 : mem[a >> 2], hwrite, 8'(a >> 2), mask));
                        end
                    end
                end
                exp_rdy   = q.size() > 0 ? q[0].rdy : 1'b1;
                exp_resp  = q.size() > 0 ? q[0].resp : 1'b0;
                exp_rdata = q.size() > 0 ? q[0].rdata : 32'h0;
            end
        end
    end
    initial forever begin
        @(negedge clk);
        chk("s0_hreadyout", 32'(hro0), 32'(m[0].exp_rdy));
        chk("s0_hresp", 32'(hresp0), 32'(m[0].exp_resp));
        chk("s0_hrdata", hrdata0, m[0].exp_rdata);
        chk("s1_hreadyout", 32'(hro1), 32'(m[1].exp_rdy));
        chk("s1_hresp", 32'(hresp1), 32'(m[1].exp_resp));
        chk("s1_hrdata", hrdata1, m[1].exp_rdata);
        exp_bus_rdy = m[0].exp_rdy & m[1].exp_rdy & ~hold;
    end
    task automatic wait_ready();
        logic r;
        nwait = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            r = hready;
            if (i == 0) first_resp = hresp0 | hresp1;
            if (r) begin
                cap_rdata = hrdata0 | hrdata1;
                cap_resp = hresp0 | hresp1;
            end else nwait++;
            @(posedge clk);
            #1 hold = 0;
            if (r) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: HREADY stayed low for 16 cycles at %0t", $time);
    endtask
    task automatic issue(input logic k, input logic [1:0] tr, input logic w, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, input logic s);
        cur = k; hsel = s; htrans = tr; hwrite = w; haddr = a; hsize = sz; hwdata = pwdata;
        hburst = 3'($urandom_range(0, 7)); hprot = 4'($urandom_range(0, 15));
        wait_ready();
        pwdata = wd;
    endtask
    task automatic drain();
        hsel = 0; htrans = 0; hwdata = pwdata;
        wait_ready();
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [1:0] tr;
        logic [2:0] sz;
        logic [31:0] a;
        int r;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hreadyout", 32'(hro0), 1);
        chk("reset_hresp", 32'(hresp0), 0);
        chk("reset_hrdata", hrdata0, 0);
        #3 rst = 0;
        @(posedge clk);
        #1;
        for (int w = 0; w < DEPTH; w++) begin
            issue(0, 2, 1, 32'(w * 4), 2, $urandom, 1);
            issue(1, 2, 1, 32'(w * 4), 2, $urandom, 1);
        end
        drain();
        issue(0, 2, 1, 32'h10, 2, 32'hDEADBEEF, 1);
        drain();
        chk("ws1_write_waits", nwait, 1);
        issue(0, 2, 0, 32'h10, 2, 0, 1);
        drain();
        chk("ws1_read_waits", nwait, 1);
        chk("ws1_read_data", cap_rdata, 32'hDEADBEEF);
        chk("ws1_read_resp", 32'(cap_resp), 0);
        chk("model_pin_deadbeef", m[0].mem[4], 32'hDEADBEEF);
        issue(0, 2, 1, 32'h12, 2, 32'h12345678, 1);
        drain();
        chk("misaligned_write_resp", 32'(cap_resp), 1);
        cur = 0; hsel = 1; htrans = 2; hwrite = 1; haddr = 32'h10; hsize = 2; hwdata = pwdata; hold = 1;
        @(posedge clk);
        #1 hold = 0; hsel = 0; htrans = 0;
        htrans = 2; hwdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1 htrans = 0;
        @(posedge clk);
        #1;
        issue(0, 2, 0, 32'h10, 2, 0, 1);
        drain();
        chk("ignored_phases_keep_word", cap_rdata, 32'hDEADBEEF);
        issue(0, 2, 1, 32'h20, 2, 0, 1);
        issue(0, 2, 1, 32'h21, 0, 32'hABABABAB, 1);
        issue(0, 2, 0, 32'h20, 2, 0, 1);
        drain();
        chk("byte_lane_write", cap_rdata, 32'h0000AB00);
        chk("model_pin_byte_lane", m[0].mem[8], 32'h0000AB00);
        issue(0, 2, 0, 32'h402, 2, 0, 1);
        drain();
        chk("oob_err1_resp", 32'(first_resp), 1);
        chk("oob_err_waits", nwait, 1);
        chk("oob_err2_resp", 32'(cap_resp), 1);
        tot = 0;
        issue(1, 2, 1, 32'h0, 2, 32'h11111111, 1); tot += nwait;
        issue(1, 3, 1, 32'h4, 2, 32'h22222222, 1); tot += nwait;
        issue(1, 3, 1, 32'h8, 2, 32'h33333333, 1); tot += nwait;
        issue(1, 2, 0, 32'h0, 2, 0, 1); tot += nwait;
        issue(1, 3, 0, 32'h4, 2, 0, 1); tot += nwait;
        chk("b2b_read0", cap_rdata, 32'h11111111);
        issue(1, 3, 0, 32'h8, 2, 0, 1); tot += nwait;
        chk("b2b_read1", cap_rdata, 32'h22222222);
        drain(); tot += nwait;
        chk("b2b_read2", cap_rdata, 32'h33333333);
        chk("b2b_no_stalls", tot, 0);
        issue(0, 2, 1, 32'h30, 2, 32'hC0FFEE01, 1);
        drain();
        issue(0, 2, 1, 32'h30, 2, 32'h55AA55AA, 1);
        hsel = 0; htrans = 0; hwdata = 32'h55AA55AA;
        #2 rst = 1;
        #1;
        chk("rst_mid_hreadyout", 32'(hro0), 1);
        chk("rst_mid_hresp", 32'(hresp0), 0);
        @(posedge clk);
        #3 rst = 0; pwdata = 0;
        @(posedge clk);
        #1;
        issue(0, 2, 0, 32'h30, 2, 0, 1);
        drain();
        chk("rst_abort_keeps_word", cap_rdata, 32'hC0FFEE01);
        issue(0, 0, 0, 32'h40, 2, 0, 1);
        issue(0, 1, 0, 32'h44, 2, 0, 1);
        chk("idle_okay_waits", nwait, 0);
        chk("idle_okay_resp", 32'(cap_resp), 0);
        drain();
        chk("busy_okay_waits", nwait, 0);
        chk("busy_okay_resp", 32'(cap_resp), 0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            tr = r < 6 ? 2'd2 : r < 8 ? 2'd3 : r == 8 ? 2'd0 : 2'd1;
            sz = $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, DEPTH * 4 - 1));
            if (sz < 3 && $urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
            if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            hold = $urandom_range(0, 7) == 0;
            issue(1'($urandom_range(0, 1)), tr, 1'($urandom_range(0, 1)), a, sz, $urandom,
                  $urandom_range(0, 9) != 0);
        end
        drain();
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
